// File: rtl/clk_switch_ctrl.sv
// Sequencer for one glitchless clock mux: deselect, select, settle, with timeout.
// Optional CLK_SWITCH_CTRL_AUTOREVERT_EN: on timeout, fall back to the previous source.
module clk_switch_ctrl #(
    parameter int N_CLOCKS      = 4,
    parameter int W_SEL         = 2,
    parameter int RESET_SEL     = 0,
    parameter int TIMEOUT_W     = 10,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [W_SEL-1:0]     req_sel,
    input  logic [N_CLOCKS-1:0]  selected_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic [W_SEL-1:0]     sel_o,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DESEL,
        SEL,
        SETTLE,
        REVERT
    } state_t;

    state_t               state_q, state_d;
    logic [W_SEL-1:0]     sel_q, sel_d;
    logic [W_SEL-1:0]     prev_q, prev_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    logic [N_CLOCKS-1:0]  sel_onehot;
    logic [N_CLOCKS-1:0]  prev_onehot;
    logic                 sel_match;
    logic                 prev_active;
    logic                 timeout_hit;
    logic                 req_illegal;

    always_comb begin
        sel_onehot  = '0;
        prev_onehot = '0;
        for (int unsigned i = 0; i < N_CLOCKS; i++) begin
            sel_onehot[i]  = (32'(sel_q) == i);
            prev_onehot[i] = (32'(prev_q) == i);
        end
        sel_match   = (selected_i == sel_onehot);
        prev_active = |(selected_i & prev_onehot);
        timeout_hit = (timeout_i != '0) && (timer_q == timeout_i);
        req_illegal = (32'(req_sel) >= 32'(N_CLOCKS));
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        prev_d   = prev_q;
        timer_d  = timer_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_illegal) begin
                        err_d = 1'b1;
                    end else if ((req_sel == sel_q) && sel_match) begin
                        done_d = 1'b1;
                    end else begin
                        prev_d  = sel_q;
                        sel_d   = req_sel;
                        timer_d = '0;
                        state_d = DESEL;
                    end
                end
            end
            DESEL, SEL: begin
                if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
                // Timeout is checked first so it wins over a same-cycle advance.
                if (timeout_hit) begin
`ifdef CLK_SWITCH_CTRL_AUTOREVERT_EN
                    sel_d   = prev_q;
                    state_d = REVERT;
`else
                    err_d   = 1'b1;
                    state_d = IDLE;
`endif
                end else if (state_q == DESEL) begin
                    if ((prev_q == sel_q) || !prev_active) begin
                        state_d = SEL;
                    end
                end else if (sel_match) begin
                    if (SETTLE_CYCLES == 0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        settle_d = SETTLE_W'(SETTLE_CYCLES - 1);
                        state_d  = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (!sel_match) begin
                    state_d = SEL;
                end else if (settle_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            REVERT: begin
`ifdef CLK_SWITCH_CTRL_AUTOREVERT_EN
                if (sel_match) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= W_SEL'(RESET_SEL);
            prev_q   <= W_SEL'(RESET_SEL);
            timer_q  <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            prev_q   <= prev_d;
            timer_q  <= timer_d;
            settle_q <= settle_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign sel_o     = sel_q;
    assign done      = done_q;
    assign err       = err_q;
    assign req_ready = ready_q;
    assign busy      = busy_q;

endmodule
